// File: rtl/pc_gen_unit.sv
// Program-counter generator for instruction fetch: holds the fetch address,
// offers it on a valid/ready handshake, and handles redirects, traps and stalls.
module pc_gen_unit #(
  parameter int unsigned          XLEN         = 32,
  parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0100_0000,
  parameter logic [XLEN-1:0]      TRAP_VECTOR  = 32'h0100_0100,
  parameter int unsigned          ILEN_BYTES   = 4,
  parameter int unsigned          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             trap_valid,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_inc,
  output logic             misaligned_err,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int unsigned ALIGN_W = $clog2(ILEN_BYTES);

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            fire;
  logic            misalign;

  // The request is outstanding for as long as we sit in RUN.
  assign fetch_valid = (state == RUN);
  assign fire        = fetch_valid & fetch_ready;
  assign misalign    = redirect_valid & (redirect_pc[ALIGN_W-1:0] != '0);
  assign pc_inc      = pc + XLEN'(ILEN_BYTES);

  always_comb begin
    pc_nxt = pc;
    if (trap_valid)          pc_nxt = TRAP_VECTOR;
    else if (misalign)       pc_nxt = TRAP_VECTOR;
    else if (redirect_valid) pc_nxt = redirect_pc;
    else if (fire)           pc_nxt = pc_inc;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT:    if (en) state_nxt = RUN;
      RUN:     if (!en && fire) state_nxt = STALL;
      STALL:   if (en) state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= BOOT;
      pc             <= RESET_VECTOR;
      misaligned_err <= 1'b0;
      fetch_count    <= '0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      misaligned_err <= misalign & ~trap_valid;
      if (fire) fetch_count <= fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_gen_unit.sv
// Scoreboard bench for pc_gen_unit: directed scenarios then random traffic,
// checked against an abstract next-pc / handshake model.
module tb_pc_gen_unit;

  localparam logic [31:0] RV = 32'h0100_0000;
  localparam logic [31:0] TV = 32'h0100_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, redirect_valid = 1'b0, trap_valid = 1'b0, fetch_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_valid, misaligned_err;
  logic [31:0] pc, pc_inc;
  logic [15:0] fetch_count;

  pc_gen_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .ILEN_BYTES(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .trap_valid(trap_valid), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .pc(pc), .pc_inc(pc_inc),
    .misaligned_err(misaligned_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        valid;
    logic        err;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference state
  logic [31:0] m_pc;
  logic        m_valid, m_err;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_pc = RV; m_valid = 1'b0; m_err = 1'b0; m_cnt = '0;
  endtask

  // One clock of the architectural rules, using the inputs held across the edge.
  task automatic model_step();
    logic fire, mis;
    fire = m_valid & fetch_ready;
    mis  = redirect_valid & (redirect_pc % 4 != 0);
    if (trap_valid || mis)  m_pc = TV;
    else if (redirect_valid) m_pc = redirect_pc;
    else if (fire)           m_pc = m_pc + 4;
    m_err   = mis & !trap_valid;
    m_cnt   = m_cnt + (fire ? 16'd1 : 16'd0);
    m_valid = en | (m_valid & !fire);
    sb.push_back('{pc: m_pc, valid: m_valid, err: m_err, cnt: m_cnt});
  endtask

  task automatic cyc(input logic e, input logic rv, input logic [31:0] rp,
                     input logic tv, input logic fr);
    en = e; redirect_valid = rv; redirect_pc = rp; trap_valid = tv; fetch_ready = fr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    n_checks++;
    if (pc !== RV || fetch_valid !== 1'b0 || misaligned_err !== 1'b0 || fetch_count !== 16'd0) begin
      n_fail++;
      $display("FAIL %s: pc=%h valid=%b err=%b cnt=%0d, required pc=%h valid=0 err=0 cnt=0",
               tag, pc, fetch_valid, misaligned_err, fetch_count, RV);
    end
  endtask

  // Monitor: DUT presents a new output set every cycle; compare against queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst && sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if (pc !== e.pc || fetch_valid !== e.valid || misaligned_err !== e.err || fetch_count !== e.cnt) begin
        n_fail++;
        $display("FAIL outputs @%0t: pc=%h valid=%b err=%b cnt=%0d, required pc=%h valid=%b err=%b cnt=%0d",
                 $time, pc, fetch_valid, misaligned_err, fetch_count, e.pc, e.valid, e.err, e.cnt);
      end
      n_checks++;
      if (pc_inc !== e.pc + 32'd4) begin
        n_fail++;
        $display("FAIL pc_inc @%0t: got %h, required %h", $time, pc_inc, e.pc + 32'd4);
      end
    end
  end

  task automatic random_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      logic        e, rv, tv, fr;
      logic [31:0] rp;
      e  = ($urandom_range(0, 9) < 7);
      rv = ($urandom_range(0, 9) < 2);
      tv = ($urandom_range(0, 19) == 0);
      fr = ($urandom_range(0, 9) < 6);
      rp = {$urandom} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) rp[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF0 | (rp & 32'hF);
      cyc(e, rv, rp, tv, fr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset_state");
    #1 rst = 1'b1;

    // Boot, then three accepted fetches
    cyc(1, 0, '0, 0, 0);
    repeat (3) cyc(1, 0, '0, 0, 1);
    // Stall request while unaccepted: hold, then accept, then frozen
    repeat (2) cyc(0, 0, '0, 0, 0);
    repeat (3) cyc(0, 0, '0, 0, 1);
    cyc(1, 0, '0, 0, 0);
    // Redirects, misaligned redirect, trap beating redirect
    cyc(1, 1, 32'h0100_2000, 0, 0);
    cyc(1, 1, 32'h0100_2002, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 1, 32'h0100_3000, 1, 0);
    // Redirect while stalled still moves pc
    cyc(0, 0, '0, 0, 1);
    cyc(0, 1, 32'h0100_4000, 0, 0);
    // Address wrap
    cyc(1, 1, 32'hFFFF_FFFC, 0, 0);
    cyc(1, 0, '0, 0, 1);
    cyc(1, 0, '0, 0, 1);

    random_cycles(400);

    // Asynchronous reset mid-run
    #1 rst = 1'b0;
    #1 check_reset_state("async_reset");
    model_reset();
    @(negedge clk);
    check_reset_state("reset_hold");
    #1 rst = 1'b1;
    cyc(1, 0, '0, 0, 1);
    cyc(1, 0, '0, 0, 1);
    random_cycles(300);

    cyc(0, 0, '0, 0, 0);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
